// File: rtl/if_fetch_ctrl_pkg.sv
// Shared types and constants for the IF-stage fetch sequencer.
package if_fetch_ctrl_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  localparam logic [ADDR_W-1:0] PC_INC       = 32'd4;
  localparam logic [ADDR_W-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

  // Instruction word tagged with the address it was fetched from.
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst;
  } fetch_pkt_t;

  // Sequential successor; wraps modulo 2^32.
  function automatic logic [ADDR_W-1:0] next_seq_pc(input logic [ADDR_W-1:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch sequencer: owns the PC, issues req/ack reads, presents instructions to decode.
// Optional fetch timeout flag enabled by defining FETCH_TIMEOUT_EN.
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC       = RESET_PC_DEF,
  parameter int unsigned       TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_addr_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] new_pc_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [DATA_W-1:0] imem_rdata_i,
  output logic              if_valid_o,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [DATA_W-1:0] if_inst_o,
  output logic              fetch_err_o
);

  fetch_state_e      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pend_tgt;
  logic              pend;
  logic              valid;
  fetch_pkt_t        out_q;
  fetch_pkt_t        hold_q;

  logic              redir;
  logic [ADDR_W-1:0] redir_tgt;
  logic              take;

  // Flush outranks branch; take means decode consumes the output register this edge.
  assign redir     = flush_i | branch_flag_i;
  assign redir_tgt = flush_i ? new_pc_i : branch_target_addr_i;
  assign take      = valid & ~stall_i;

  assign imem_req_o  = (state == ST_FETCH);
  assign imem_addr_o = pc;
  assign if_valid_o  = valid;
  assign if_pc_o     = out_q.pc;
  assign if_inst_o   = out_q.inst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      pc       <= RESET_PC;
      pend     <= 1'b0;
      pend_tgt <= '0;
      valid    <= 1'b0;
      out_q    <= '0;
      hold_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state <= ST_FETCH;
          if (redir) pc <= redir_tgt;
        end
        ST_FETCH: begin
          if (imem_ack_i) begin
            if (redir || pend) begin
              // Data belongs to the stale path; restart at the newest target.
              pc    <= redir ? redir_tgt : pend_tgt;
              pend  <= 1'b0;
              valid <= 1'b0;
            end else if (valid && stall_i) begin
              hold_q <= {pc, imem_rdata_i};
              pc     <= next_seq_pc(pc);
              state  <= ST_HOLD;
            end else begin
              out_q <= {pc, imem_rdata_i};
              valid <= 1'b1;
              pc    <= next_seq_pc(pc);
            end
          end else if (redir) begin
            // Request cannot be withdrawn; remember where to go once it completes.
            pend     <= 1'b1;
            pend_tgt <= redir_tgt;
            valid    <= 1'b0;
          end else if (take) begin
            valid <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (redir) begin
            valid <= 1'b0;
            pc    <= redir_tgt;
            state <= ST_FETCH;
          end else if (!stall_i) begin
            out_q <= hold_q;
            state <= ST_FETCH;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] to_cnt;
  logic             err;

  // Counts consecutive unacked FETCH cycles; flag is sticky until flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
      err    <= 1'b0;
    end else begin
      if (state != ST_FETCH || imem_ack_i) begin
        to_cnt <= '0;
      end else if (to_cnt != CNT_W'(TIMEOUT_CYCLES)) begin
        to_cnt <= to_cnt + CNT_W'(1);
      end
      if (flush_i) begin
        err <= 1'b0;
      end else if (state == ST_FETCH && !imem_ack_i && to_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        err <= 1'b1;
      end
    end
  end

  assign fetch_err_o = err;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
  assign fetch_err_o        = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: directed scenarios plus a randomized scoreboard run.
module tb_if_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam int unsigned TO_CYC = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_addr_i = '0;
  logic        flush_i = 1'b0;
  logic [31:0] new_pc_i = '0;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        fetch_err_o;

  int vectors = 0;
  int miscompares = 0;
  int ack_mode = 0;   // 0 never, 1 every cycle, 2 after ack_delay waits, 3 random
  int ack_delay = 0;
  int wait_cnt = 0;

  // Values seen in the cycle just before the most recent edge.
  logic        p_req, p_ack, p_valid, p_stall, p_br, p_fl;
  logic [31:0] p_addr, p_pc, p_inst, p_bt, p_np;

  always #5 clk = ~clk;

  if_fetch_ctrl #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .branch_flag_i(branch_flag_i),
    .branch_target_addr_i(branch_target_addr_i), .flush_i(flush_i), .new_pc_i(new_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ack_i(imem_ack_i),
    .imem_rdata_i(imem_rdata_i), .if_valid_o(if_valid_o), .if_pc_o(if_pc_o),
    .if_inst_o(if_inst_o), .fetch_err_o(fetch_err_o)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  // Instruction memory: answers only while a request is up, data valid only with ack.
  initial begin
    forever begin
      @(negedge clk);
      if (rst || !imem_req_o) begin
        imem_ack_i = 1'b0;
        wait_cnt   = 0;
      end else begin
        case (ack_mode)
          1: imem_ack_i = 1'b1;
          2: imem_ack_i = (wait_cnt >= ack_delay);
          3: imem_ack_i = ($urandom_range(0, 1) == 1);
          default: imem_ack_i = 1'b0;
        endcase
        wait_cnt = imem_ack_i ? 0 : wait_cnt + 1;
      end
      imem_rdata_i = imem_ack_i ? mem_word(imem_addr_o) : 32'hDEAD_BEEF;
    end
  end

  // Apply inputs for one cycle, record the pre-edge view, return 1 after the edge.
  task automatic step(input logic st, input logic br, input logic [31:0] bt,
                      input logic fl, input logic [31:0] np);
    stall_i = st; branch_flag_i = br; branch_target_addr_i = bt; flush_i = fl; new_pc_i = np;
    @(negedge clk); #1;
    p_req = imem_req_o; p_addr = imem_addr_o; p_ack = imem_ack_i;
    p_valid = if_valid_o; p_pc = if_pc_o; p_inst = if_inst_o;
    p_stall = st; p_br = br; p_bt = bt; p_fl = fl; p_np = np;
    @(posedge clk); #1;
  endtask

  task automatic go(input logic st);
    step(st, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic test_reset();
    rst = 1'b1; ack_mode = 1;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (if_valid_o !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %0b want 0", if_valid_o); end
    vectors++; if (if_pc_o !== 32'h0) begin miscompares++; $display("FAIL rst_pc: got %h want 0", if_pc_o); end
    vectors++; if (if_inst_o !== 32'h0) begin miscompares++; $display("FAIL rst_inst: got %h want 0", if_inst_o); end
    vectors++; if (imem_req_o !== 1'b0) begin miscompares++; $display("FAIL rst_req: got %0b want 0", imem_req_o); end
    vectors++; if (imem_addr_o !== RST_PC) begin miscompares++; $display("FAIL rst_addr: got %h want %h", imem_addr_o, RST_PC); end
    vectors++; if (fetch_err_o !== 1'b0) begin miscompares++; $display("FAIL rst_err: got %0b want 0", fetch_err_o); end
    rst = 1'b0;
  endtask

  // Starts from RESET_PC near the top of memory so the stream wraps through zero.
  task automatic test_sequential();
    logic [31:0] e;
    go(1'b0);
    vectors++; if (p_req !== 1'b0) begin miscompares++; $display("FAIL idle_req: got %0b want 0", p_req); end
    vectors++; if (if_valid_o !== 1'b0) begin miscompares++; $display("FAIL idle_valid: got %0b want 0", if_valid_o); end
    for (int k = 0; k < 6; k++) begin
      e = RST_PC + 32'(4 * k);
      go(1'b0);
      vectors++; if ({p_req, p_ack, p_addr} !== {2'b11, e}) begin miscompares++; $display("FAIL seq_addr: got req=%0b ack=%0b addr=%h want %h", p_req, p_ack, p_addr, e); end
      vectors++; if ({if_valid_o, if_pc_o, if_inst_o} !== {1'b1, e, mem_word(e)}) begin miscompares++; $display("FAIL seq_out: got v=%0b pc=%h inst=%h want pc=%h", if_valid_o, if_pc_o, if_inst_o, e); end
    end
  endtask

  task automatic test_branch_pending();
    ack_mode = 2; ack_delay = 3;
    go(1'b0);
    vectors++; if ({p_ack, p_addr, if_valid_o} !== {1'b0, 32'h10, 1'b0}) begin miscompares++; $display("FAIL bp_wait0: got ack=%0b addr=%h v=%0b", p_ack, p_addr, if_valid_o); end
    step(1'b0, 1'b1, 32'h100, 1'b0, 32'h0);
    vectors++; if ({imem_req_o, imem_addr_o, if_valid_o} !== {1'b1, 32'h10, 1'b0}) begin miscompares++; $display("FAIL bp_hold_addr: got req=%0b addr=%h v=%0b want addr 10", imem_req_o, imem_addr_o, if_valid_o); end
    go(1'b0);
    vectors++; if ({p_ack, imem_addr_o} !== {1'b0, 32'h10}) begin miscompares++; $display("FAIL bp_wait2: got ack=%0b addr=%h", p_ack, imem_addr_o); end
    go(1'b0);
    vectors++; if (p_ack !== 1'b1) begin miscompares++; $display("FAIL bp_ack: got %0b want 1", p_ack); end
    vectors++; if ({if_valid_o, imem_addr_o} !== {1'b0, 32'h100}) begin miscompares++; $display("FAIL bp_discard: got v=%0b addr=%h want v=0 addr=100", if_valid_o, imem_addr_o); end
    ack_mode = 1;
    go(1'b0);
    vectors++; if ({if_valid_o, if_pc_o, if_inst_o} !== {1'b1, 32'h100, mem_word(32'h100)}) begin miscompares++; $display("FAIL bp_target: got v=%0b pc=%h inst=%h want pc=100", if_valid_o, if_pc_o, if_inst_o); end
  endtask

  task automatic test_hold();
    step(1'b0, 1'b1, 32'h4, 1'b0, 32'h0);
    vectors++; if ({if_valid_o, imem_addr_o} !== {1'b0, 32'h4}) begin miscompares++; $display("FAIL hd_redir: got v=%0b addr=%h want v=0 addr=4", if_valid_o, imem_addr_o); end
    go(1'b0);
    vectors++; if ({if_valid_o, if_pc_o} !== {1'b1, 32'h4}) begin miscompares++; $display("FAIL hd_first: got v=%0b pc=%h want pc=4", if_valid_o, if_pc_o); end
    go(1'b1);
    vectors++; if ({p_ack, p_addr} !== {1'b1, 32'h8}) begin miscompares++; $display("FAIL hd_ack8: got ack=%0b addr=%h", p_ack, p_addr); end
    vectors++; if ({imem_req_o, if_valid_o, if_pc_o} !== {2'b01, 32'h4}) begin miscompares++; $display("FAIL hd_enter: got req=%0b v=%0b pc=%h want req=0 v=1 pc=4", imem_req_o, if_valid_o, if_pc_o); end
    go(1'b1);
    vectors++; if ({imem_req_o, if_valid_o, if_pc_o} !== {2'b01, 32'h4}) begin miscompares++; $display("FAIL hd_stay: got req=%0b v=%0b pc=%h want req=0 v=1 pc=4", imem_req_o, if_valid_o, if_pc_o); end
    go(1'b0);
    vectors++; if ({if_valid_o, if_pc_o, if_inst_o} !== {1'b1, 32'h8, mem_word(32'h8)}) begin miscompares++; $display("FAIL hd_release: got v=%0b pc=%h inst=%h want pc=8", if_valid_o, if_pc_o, if_inst_o); end
    vectors++; if ({imem_req_o, imem_addr_o} !== {1'b1, 32'hC}) begin miscompares++; $display("FAIL hd_next_addr: got req=%0b addr=%h want addr=c", imem_req_o, imem_addr_o); end
    go(1'b0);
    vectors++; if ({if_valid_o, if_pc_o} !== {1'b1, 32'hC}) begin miscompares++; $display("FAIL hd_after: got v=%0b pc=%h want pc=c", if_valid_o, if_pc_o); end
  endtask

  task automatic test_flush_priority();
    go(1'b1);
    vectors++; if ({imem_req_o, if_valid_o, if_pc_o} !== {2'b01, 32'hC}) begin miscompares++; $display("FAIL fl_enter_hold: got req=%0b v=%0b pc=%h", imem_req_o, if_valid_o, if_pc_o); end
    step(1'b1, 1'b1, 32'h200, 1'b1, 32'h180);
    vectors++; if ({if_valid_o, imem_req_o, imem_addr_o} !== {2'b01, 32'h180}) begin miscompares++; $display("FAIL fl_prio: got v=%0b req=%0b addr=%h want v=0 req=1 addr=180", if_valid_o, imem_req_o, imem_addr_o); end
    go(1'b0);
    vectors++; if ({if_valid_o, if_pc_o, if_inst_o} !== {1'b1, 32'h180, mem_word(32'h180)}) begin miscompares++; $display("FAIL fl_target: got v=%0b pc=%h inst=%h want pc=180", if_valid_o, if_pc_o, if_inst_o); end
  endtask

  task automatic test_timeout();
    logic exp_err;
    ack_mode = 0;
    for (int n = 1; n <= 18; n++) begin
      go(1'b0);
`ifdef FETCH_TIMEOUT_EN
      exp_err = (n >= int'(TO_CYC));
`else
      exp_err = 1'b0;
`endif
      vectors++; if ({p_req, p_ack, p_addr} !== {2'b10, 32'h184}) begin miscompares++; $display("FAIL to_req_held: got req=%0b ack=%0b addr=%h want addr=184", p_req, p_ack, p_addr); end
      vectors++; if (fetch_err_o !== exp_err) begin miscompares++; $display("FAIL to_err cycle %0d: got %0b want %0b", n, fetch_err_o, exp_err); end
    end
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h40);
    vectors++; if ({fetch_err_o, imem_req_o, imem_addr_o} !== {2'b01, 32'h184}) begin miscompares++; $display("FAIL to_flush_clear: got err=%0b req=%0b addr=%h", fetch_err_o, imem_req_o, imem_addr_o); end
    go(1'b0);
    vectors++; if (fetch_err_o !== 1'b0) begin miscompares++; $display("FAIL to_stays_clear: got %0b want 0", fetch_err_o); end
    ack_mode = 1;
    go(1'b0);
    vectors++; if ({if_valid_o, imem_addr_o, fetch_err_o} !== {1'b0, 32'h40, 1'b0}) begin miscompares++; $display("FAIL to_pend_apply: got v=%0b addr=%h err=%0b want addr=40", if_valid_o, imem_addr_o, fetch_err_o); end
    go(1'b0);
    vectors++; if ({if_valid_o, if_pc_o} !== {1'b1, 32'h40}) begin miscompares++; $display("FAIL to_resume: got v=%0b pc=%h want pc=40", if_valid_o, if_pc_o); end
  endtask

  // Scoreboard: consumed instructions must follow pc+4 order unless redirected,
  // redirects kill the output, stalls freeze it, requests are never withdrawn.
  task automatic test_random();
    logic [31:0] exp_next, tgt, bt, np;
    logic        st, br, fl, redir;
    int          takes = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ack_mode = 3;
    exp_next = RST_PC;
    for (int i = 0; i < 500; i++) begin
      st = ($urandom_range(0, 9) < 3);
      br = (i != 0) && ($urandom_range(0, 99) < 8);
      fl = (i != 0) && ($urandom_range(0, 99) < 4);
      bt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'h0000_0FFC);
      np = $urandom() & 32'h0000_0FFC;
      step(st, br, bt, fl, np);
      redir = p_fl | p_br;
      tgt   = p_fl ? p_np : p_bt;
      if (p_valid && !p_stall) begin
        vectors++; if (p_pc !== exp_next) begin miscompares++; $display("FAIL rnd_order cycle %0d: got pc=%h want %h", i, p_pc, exp_next); end
        vectors++; if (p_inst !== mem_word(p_pc)) begin miscompares++; $display("FAIL rnd_data cycle %0d: got %h want %h", i, p_inst, mem_word(p_pc)); end
        exp_next = p_pc + 32'd4;
        takes++;
      end
      if (redir) begin
        exp_next = tgt;
        vectors++; if (if_valid_o !== 1'b0) begin miscompares++; $display("FAIL rnd_kill cycle %0d: got v=%0b want 0", i, if_valid_o); end
      end else if (p_valid && p_stall) begin
        vectors++; if ({if_valid_o, if_pc_o, if_inst_o} !== {1'b1, p_pc, p_inst}) begin miscompares++; $display("FAIL rnd_stall cycle %0d: got v=%0b pc=%h want pc=%h", i, if_valid_o, if_pc_o, p_pc); end
      end
      if (p_req && !p_ack) begin
        vectors++; if ({imem_req_o, imem_addr_o} !== {1'b1, p_addr}) begin miscompares++; $display("FAIL rnd_req_stable cycle %0d: got req=%0b addr=%h want %h", i, imem_req_o, imem_addr_o, p_addr); end
      end
    end
    vectors++; if (takes < 50) begin miscompares++; $display("FAIL rnd_progress: got %0d deliveries want at least 50", takes); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch_pending();
    test_hold();
    test_flush_priority();
    test_timeout();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
